can_dma_sched: RTL

- Sequences and arbitrates the single shared DMA memory port between the CAN TX path and the RX path.
- TX job: three DMA reads (send setting, data word 1, data word 2). The assembled frame is presented to the CAN main flow with tx_pending.
- RX job: three DMA writes (received setting, data word 1, data word 2).
- Replaces the free-running per-path DMA state machines in the CAN top level. One memory transaction is in flight at a time; the block arbitrates between the two paths and detects timeouts.

---
 rtl/can_dma_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/can_dma_sched.sv
// can_dma_sched: serialises the CAN TX fetch and RX store jobs onto one DMA
// port. Each job is three single-word transactions; one transaction is in
// flight at a time, the two paths are round-robin arbitrated and a stuck
// transaction is aborted after TIMEOUT_CYCLES.
module can_dma_sched #(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    ADDR_WIDTH        = 20,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SETTING_SEND = 20'hA0001,
    parameter logic [ADDR_WIDTH-1:0] ADDR_DATA_SEND_1  = 20'hA0002,
    parameter logic [ADDR_WIDTH-1:0] ADDR_DATA_SEND_2  = 20'hA0003,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SETTING_RECV = 20'hB0001,
    parameter logic [ADDR_WIDTH-1:0] ADDR_DATA_RECV_1  = 20'hB0002,
    parameter logic [ADDR_WIDTH-1:0] ADDR_DATA_RECV_2  = 20'hB0003,
    parameter int                    TIMEOUT_CYCLES    = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    tx_send_i,
    input  logic                    tx_busy_i,
    output logic                    tx_pending_o,
    output logic [DATA_WIDTH-1:0]   tx_setting_o,
    output logic [2*DATA_WIDTH-1:0] tx_data_o,
    input  logic                    rx_frame_ready_i,
    input  logic [DATA_WIDTH-1:0]   rx_setting_i,
    input  logic [2*DATA_WIDTH-1:0] rx_data_i,
    output logic                    rx_overrun_o,
    output logic                    dma_error_o,
    input  logic [DATA_WIDTH-1:0]   data_rd,
    output logic [ADDR_WIDTH-1:0]   addr_rd,
    output logic                    rd_en,
    input  logic                    rd_done,
    input  logic                    rd_busy,
    output logic [DATA_WIDTH-1:0]   data_wr,
    output logic [ADDR_WIDTH-1:0]   addr_wr,
    output logic                    wr_en,
    input  logic                    wr_done,
    input  logic                    wr_busy
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   setting;
        logic [2*DATA_WIDTH-1:0] data;
    } rx_frame_t;

    state_t          state;
    logic            grant_rx;   // path owning the current job (1 = RX)
    logic            last_rx;    // path granted most recently
    logic [1:0]      word_idx;
    logic [CW-1:0]   tmo_cnt;
    logic            tx_req;
    logic            rx_full;
    rx_frame_t       rx_buf;

    logic                  cur_done, cur_busy, done_ok, tmo_hit, job_end;
    logic [ADDR_WIDTH-1:0] tx_addr, rx_addr;
    logic [DATA_WIDTH-1:0] rx_word;

    assign cur_done = grant_rx ? wr_done : rd_done;
    assign cur_busy = grant_rx ? wr_busy : rd_busy;
    // A done coinciding with our own strobe belongs to nothing we issued.
    assign done_ok  = (state == S_WAIT) && cur_done && !rd_en && !wr_en;
    assign tmo_hit  = (state == S_WAIT) && !done_ok && (tmo_cnt == TMO_LAST);
    assign job_end  = (done_ok && (word_idx == 2'd2)) || tmo_hit;

    // Address / write-data selection for the current word of the job.
    always_comb begin
        tx_addr = ADDR_SETTING_SEND;
        rx_addr = ADDR_SETTING_RECV;
        rx_word = rx_buf.setting;
        case (word_idx)
            2'd1: begin
                tx_addr = ADDR_DATA_SEND_1;
                rx_addr = ADDR_DATA_RECV_1;
                rx_word = rx_buf.data[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            2'd2: begin
                tx_addr = ADDR_DATA_SEND_2;
                rx_addr = ADDR_DATA_RECV_2;
                rx_word = rx_buf.data[DATA_WIDTH-1:0];
            end
            default: ;
        endcase
    end

    // Request side: TX request latch and the one-deep RX frame buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_req       <= 1'b0;
            rx_full      <= 1'b0;
            rx_buf       <= '0;
            rx_overrun_o <= 1'b0;
        end else begin
            rx_overrun_o <= 1'b0;
            if (job_end && !grant_rx)
                tx_req <= 1'b0;
            else if (tx_send_i && !tx_req && !tx_pending_o)
                tx_req <= 1'b1;
            if (rx_frame_ready_i) begin
                if (rx_full) begin
                    rx_overrun_o <= 1'b1;
                end else begin
                    rx_buf  <= '{setting: rx_setting_i, data: rx_data_i};
                    rx_full <= 1'b1;
                end
            end
            if (job_end && grant_rx)
                rx_full <= 1'b0;
        end
    end

    // Job sequencer: arbitrate, issue, wait for done or timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            grant_rx     <= 1'b0;
            last_rx      <= 1'b1;
            word_idx     <= 2'd0;
            tmo_cnt      <= '0;
            tx_pending_o <= 1'b0;
            tx_setting_o <= '0;
            tx_data_o    <= '0;
            dma_error_o  <= 1'b0;
            addr_rd      <= '0;
            rd_en        <= 1'b0;
            addr_wr      <= '0;
            data_wr      <= '0;
            wr_en        <= 1'b0;
        end else begin
            rd_en       <= 1'b0;
            wr_en       <= 1'b0;
            dma_error_o <= 1'b0;
            if (tx_pending_o && tx_busy_i)
                tx_pending_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_req || rx_full)
                        state <= S_ARB;
                end
                S_ARB: begin
                    if (tx_req || rx_full) begin
                        // On a tie, the path not served last time wins.
                        grant_rx <= (tx_req && rx_full) ? !last_rx : rx_full;
                        last_rx  <= (tx_req && rx_full) ? !last_rx : rx_full;
                        word_idx <= 2'd0;
                        state    <= S_ISSUE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (!cur_busy) begin
                        tmo_cnt <= '0;
                        if (grant_rx) begin
                            addr_wr <= rx_addr;
                            data_wr <= rx_word;
                            wr_en   <= 1'b1;
                        end else begin
                            addr_rd <= tx_addr;
                            rd_en   <= 1'b1;
                        end
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_ok) begin
                        if (!grant_rx) begin
                            case (word_idx)
                                2'd0:    tx_setting_o                         <= data_rd;
                                2'd1:    tx_data_o[2*DATA_WIDTH-1:DATA_WIDTH] <= data_rd;
                                default: tx_data_o[DATA_WIDTH-1:0]            <= data_rd;
                            endcase
                        end
                        if (word_idx == 2'd2) begin
                            if (!grant_rx)
                                tx_pending_o <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            word_idx <= word_idx + 2'd1;
                            state    <= S_ISSUE;
                        end
                    end else if (tmo_hit) begin
                        dma_error_o <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
